// File: rtl/key_bounce_gen.sv
`default_nettype none
// ============================================================================
// Module      : key_bounce_gen
// Description : Turns a one-cycle press request into an active-low mechanical
//               key waveform: bouncing fall, stable hold, bouncing rise.
//               Bounce segment lengths come from a 16-bit Galois LFSR.
// Revision    : 1.0 - initial release
// ============================================================================
module key_bounce_gen #(
  parameter int          CLK_FREQ_MHZ  = 20,
  parameter int          GLITCH_MAX_NS = 150,
  parameter int          BOUNCE_EDGES  = 4,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic        clk_i,
  input  logic        srst_i,
  input  logic        press_i,
  input  logic [15:0] hold_cycles_i,
  output logic        key_o,
  output logic        busy_o,
  output logic        done_o
);

  localparam int          CLK_TIME_NS    = 1000 / CLK_FREQ_MHZ;
  localparam int          GLITCH_RAW     = GLITCH_MAX_NS / CLK_TIME_NS;
  localparam int          GLITCH_MAX_CYC = (GLITCH_RAW < 1) ? 1 : GLITCH_RAW;
  localparam logic [15:0] SEG_DIV        = 16'(GLITCH_MAX_CYC);
  // Bounce toggles must be even so the line settles at the level of the main edge
  localparam logic [15:0] EDGES_EVEN     = 16'(BOUNCE_EDGES) & 16'hFFFE;
  // An all-zero Galois LFSR never leaves zero, so substitute a non-zero seed
  localparam logic [15:0] SEED_EFF       = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  // Right-shift Galois mask for x^16 + x^14 + x^13 + x^11
  localparam logic [15:0] LFSR_TAPS      = 16'hB400;

  localparam logic [1:0] ST_IDLE           = 2'd0;
  localparam logic [1:0] ST_PRESS_BOUNCE   = 2'd1;
  localparam logic [1:0] ST_HOLD           = 2'd2;
  localparam logic [1:0] ST_RELEASE_BOUNCE = 2'd3;

  logic [1:0]  state_q,    state_d;
  logic        key_q,      key_d;
  logic        done_q,     done_d;
  logic [15:0] lfsr_q,     lfsr_d;
  logic [15:0] edge_cnt_q, edge_cnt_d;
  logic [15:0] timer_q,    timer_d;
  logic [15:0] hold_q,     hold_d;

  logic [15:0] seg_len;
  logic [15:0] hold_in_eff;

  // LFSR step, random segment length and clamped hold request
  always_comb begin
    lfsr_d      = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    seg_len     = (lfsr_q % SEG_DIV) + 16'd1;
    hold_in_eff = (hold_cycles_i == 16'd0) ? 16'd1 : hold_cycles_i;
  end

  // State register: all sequential state with synchronous reset
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q    <= ST_IDLE;
      key_q      <= 1'b1;
      done_q     <= 1'b0;
      lfsr_q     <= SEED_EFF;
      edge_cnt_q <= 16'd0;
      timer_q    <= 16'd0;
      hold_q     <= 16'd0;
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      done_q     <= done_d;
      lfsr_q     <= lfsr_d;
      edge_cnt_q <= edge_cnt_d;
      timer_q    <= timer_d;
      hold_q     <= hold_d;
    end
  end

  // Next-state logic: timer_q counts cycles left in the current segment
  always_comb begin
    state_d    = state_q;
    key_d      = key_q;
    done_d     = 1'b0;
    edge_cnt_d = edge_cnt_q;
    timer_d    = timer_q;
    hold_d     = hold_q;
    case (state_q)
      ST_IDLE: begin
        if (press_i) begin
          hold_d     = hold_in_eff;
          key_d      = 1'b0;
          edge_cnt_d = EDGES_EVEN;
          if (EDGES_EVEN == 16'd0) begin
            state_d = ST_HOLD;
            timer_d = hold_in_eff;
          end else begin
            state_d = ST_PRESS_BOUNCE;
            timer_d = seg_len;
          end
        end
      end
      ST_PRESS_BOUNCE: begin
        if (timer_q == 16'd1) begin
          key_d      = ~key_q;
          edge_cnt_d = edge_cnt_q - 16'd1;
          if (edge_cnt_q == 16'd1) begin
            state_d = ST_HOLD;
            timer_d = hold_q;
          end else begin
            timer_d = seg_len;
          end
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      ST_HOLD: begin
        if (timer_q == 16'd1) begin
          key_d      = 1'b1;
          edge_cnt_d = EDGES_EVEN;
          if (EDGES_EVEN == 16'd0) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            timer_d = 16'd0;
          end else begin
            state_d = ST_RELEASE_BOUNCE;
            timer_d = seg_len;
          end
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      ST_RELEASE_BOUNCE: begin
        if (timer_q == 16'd1) begin
          key_d      = ~key_q;
          edge_cnt_d = edge_cnt_q - 16'd1;
          if (edge_cnt_q == 16'd1) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            timer_d = 16'd0;
          end else begin
            timer_d = seg_len;
          end
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        key_d   = 1'b1;
      end
    endcase
  end

  // Outputs come straight from registers
  always_comb begin
    key_o  = key_q;
    busy_o = (state_q != ST_IDLE);
    done_o = done_q;
  end

endmodule
`default_nettype wire
